// File: rtl/if_stage_pkg.sv
// Shared front-end definitions for the fetch stage: bus widths, reset pc and
// the branch-redirect state encoding.
package if_stage_pkg;

    localparam int          BR_BUS_WD       = 32;
    localparam int          FS_TO_DS_BUS_WD = 64;
    localparam logic [31:0] RESET_PC        = 32'hbfc0_0000;
    // fs_pc resets one word early so the first sequential nextpc is RESET_PC
    localparam logic [31:0] FS_PC_RESET     = RESET_PC - 32'd4;

    typedef enum logic [1:0] {
        BR_NONE     = 2'd0,
        BR_WAIT_DS  = 2'd1,
        BR_WAIT_TGT = 2'd2
    } br_state_e;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_br_redirect.sv
// Branch redirect tracker: remembers a taken branch until its delay slot and
// then its target have both entered the fetch stage, and produces nextpc.
module if_br_redirect
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ds_allowin,
    input  logic        fs_valid,
    input  logic        fs_enter,
    input  logic [31:0] fs_pc,
    output logic [31:0] nextpc
);

    br_state_e   state;
    br_state_e   state_next;
    logic [31:0] br_target_r;
    logic        capture;

    // a branch arriving while a redirect is still pending sits in a delay slot and is dropped
    assign capture = br_taken && ds_allowin && (state == BR_NONE);

    // redirect state and captured target
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BR_NONE;
            br_target_r <= 32'h0000_0000;
        end else begin
            state <= state_next;
            if (capture) begin
                br_target_r <= br_target;
            end
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            BR_NONE: begin
                if (!capture) begin
                    state_next = BR_NONE;
                end else if (fs_valid && fs_enter) begin
                    state_next = BR_NONE;
                end else if (fs_valid || fs_enter) begin
                    state_next = BR_WAIT_TGT;
                end else begin
                    state_next = BR_WAIT_DS;
                end
            end
            BR_WAIT_DS: begin
                if (fs_enter) begin
                    state_next = BR_WAIT_TGT;
                end else begin
                    state_next = BR_WAIT_DS;
                end
            end
            BR_WAIT_TGT: begin
                if (fs_enter) begin
                    state_next = BR_NONE;
                end else begin
                    state_next = BR_WAIT_TGT;
                end
            end
            default: state_next = BR_NONE;
        endcase
    end

    // fetch address selection; with IF occupied the delay slot is already in, so go straight to the target
    always_comb begin
        nextpc = seq_pc(fs_pc);
        if (capture && fs_valid) begin
            nextpc = br_target;
        end else if (state == BR_WAIT_TGT) begin
            nextpc = br_target_r;
        end else begin
            nextpc = seq_pc(fs_pc);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with a single-outstanding SRAM-like request port.
// Optional macro IF_ADEF_EN adds fs_adef: misaligned fetch pcs enter IF without a request.
module if_stage
    import if_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD:0]         br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_req,
    output logic [31:0]                inst_sram_addr,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
`ifdef IF_ADEF_EN
    ,
    output logic                       fs_adef
`endif
);

    logic        fs_valid;
    logic        inst_valid;
    logic [31:0] fs_pc;
    logic [31:0] inst_r;
    logic [31:0] nextpc;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        accept;
    logic        adef_enter;
    logic        fs_enter;
    logic        leave;

    assign fs_ready_go    = inst_valid;
    assign fs_allowin     = !fs_valid || (fs_ready_go && ds_allowin);
    assign fs_to_ds_valid = fs_valid && inst_valid;
    assign leave          = fs_to_ds_valid && ds_allowin;
    assign accept         = inst_sram_req && inst_sram_addr_ok;
    assign fs_enter       = accept || adef_enter;
    assign inst_sram_addr = nextpc;
    // before IF holds anything, decode is shown the pc about to be fetched (the delay slot)
    assign fs_to_ds_bus   = {inst_r, (fs_valid ? fs_pc : nextpc)};

`ifdef IF_ADEF_EN
    logic misaligned;
    logic adef_r;

    assign misaligned    = (nextpc[1:0] != 2'b00);
    assign adef_enter    = fs_allowin && !reset && misaligned;
    assign inst_sram_req = fs_allowin && !reset && !misaligned;
    assign fs_adef       = fs_valid && adef_r;

    // address-error flag travels with the pc it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            adef_r <= 1'b0;
        end else if (accept) begin
            adef_r <= 1'b0;
        end else if (adef_enter) begin
            adef_r <= 1'b1;
        end
    end
`else
    assign adef_enter    = 1'b0;
    assign inst_sram_req = fs_allowin && !reset;
`endif

    // fetch-stage occupancy, pc and returned instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid   <= 1'b0;
            inst_valid <= 1'b0;
            fs_pc      <= FS_PC_RESET;
            inst_r     <= 32'h0000_0000;
        end else if (accept) begin
            fs_valid   <= 1'b1;
            fs_pc      <= nextpc;
            inst_valid <= 1'b0;
        end else if (adef_enter) begin
            fs_valid   <= 1'b1;
            fs_pc      <= nextpc;
            inst_valid <= 1'b1;
            inst_r     <= 32'h0000_0000;
        end else if (leave) begin
            fs_valid   <= 1'b0;
            inst_valid <= 1'b0;
        end else if (inst_sram_data_ok) begin
            inst_r     <= inst_sram_rdata;
            inst_valid <= 1'b1;
        end
    end

    if_br_redirect u_br_redirect (
        .clk        (clk),
        .reset      (reset),
        .br_taken   (br_bus[BR_BUS_WD]),
        .br_target  (br_bus[BR_BUS_WD-1:0]),
        .ds_allowin (ds_allowin),
        .fs_valid   (fs_valid),
        .fs_enter   (fs_enter),
        .fs_pc      (fs_pc),
        .nextpc     (nextpc)
    );

endmodule
